integer_reservation_station: RTL and testbench

Multi-entry reservation station for the integer unit: generalises the single-slot station to ENTRY_COUNT slots, BUS_COUNT result buses, and a registered, back-pressured result port.
- Accepts dispatched ops with operands either preloaded or tagged by producer.
- Snoops all result buses to wake waiting operands.
- Issues the lowest-index ready entry to a one-stage ALU and presents the result with a valid/ready handshake to the bus arbiter.

---
 rtl/integer_reservation_station_pkg.sv | 18 +
 rtl/integer_reservation_station_alu.sv | 39 +++
 rtl/integer_reservation_station.sv | 182 ++++++++++++++++++
 tb/tb_integer_reservation_station.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integer_reservation_station_pkg.sv
// Shared definitions for the integer execution cluster.
// OP_* : ALU operation codes carried by dispatched ops (OP_WIDTH bits wide).
package integer_reservation_station_pkg;

  localparam int OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_SLL  = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_SLTU = 4'd8;
  localparam logic [OP_WIDTH-1:0] OP_SLT  = 4'd9;

endpackage

// File: rtl/integer_reservation_station_alu.sv
// integer_alu: purely combinational integer ALU.
//   operation : op code (OP_* from the package); unknown codes give 0
//   a, b      : SIZE-bit operands; shifts use the low $clog2(SIZE) bits of b
//   result    : SIZE-bit wrap-around result; compares return 1/0 zero-extended
module integer_alu
  import integer_reservation_station_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [OP_WIDTH-1:0] operation,
  input  logic [SIZE-1:0]     a,
  input  logic [SIZE-1:0]     b,
  output logic [SIZE-1:0]     result
);

  localparam int SHIFT_SIZE = $clog2(SIZE);

  logic [SHIFT_SIZE-1:0] shift_amount;

  assign shift_amount = b[SHIFT_SIZE-1:0];

  always_comb begin
    result = '0;
    case (operation)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shift_amount;
      OP_SRL:  result = a >> shift_amount;
      OP_SRA:  result = $signed(a) >>> shift_amount;
      OP_SLTU: result = {{(SIZE-1){1'b0}}, (a < b)};
      OP_SLT:  result = {{(SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/integer_reservation_station.sv
// integer_reservation_station: ENTRY_COUNT-slot reservation station for the
// integer unit with BUS_COUNT snooped result buses and a registered,
// back-pressured result port.
//   clock, reset (sync, active-high), flush (same effect as reset)
//   load_*        : dispatch port; load_ready/load_tag describe the lowest free entry
//   bus_*         : flattened result buses, bus i at [i*W +: W]
//   result_*      : valid/ready result register, tag = BASE_TAG + entry index
//   occupied_count: number of occupied entries
module integer_reservation_station
  import integer_reservation_station_pkg::*;
#(
  parameter int SIZE        = 32,
  parameter int ENTRY_COUNT = 4,
  parameter int TAG_SIZE    = 4,
  parameter int BASE_TAG    = 0,
  parameter int BUS_COUNT   = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              load_valid,
  output logic                              load_ready,
  output logic [TAG_SIZE-1:0]               load_tag,
  input  logic [OP_WIDTH-1:0]               load_operation,
  input  logic                              load_a_preloaded,
  input  logic [TAG_SIZE-1:0]               load_a_source,
  input  logic [SIZE-1:0]                   load_a_value,
  input  logic                              load_b_preloaded,
  input  logic [TAG_SIZE-1:0]               load_b_source,
  input  logic [SIZE-1:0]                   load_b_value,
  input  logic [BUS_COUNT-1:0]              bus_asserted,
  input  logic [BUS_COUNT*TAG_SIZE-1:0]     bus_source,
  input  logic [BUS_COUNT*SIZE-1:0]         bus_value,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic [TAG_SIZE-1:0]               result_tag,
  output logic [SIZE-1:0]                   result_value,
  output logic [$clog2(ENTRY_COUNT+1)-1:0]  occupied_count
);

  localparam int INDEX_SIZE = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
  localparam int COUNT_SIZE = $clog2(ENTRY_COUNT + 1);

  typedef logic [INDEX_SIZE-1:0] index_t;

  typedef struct packed {
    logic            hit;
    logic [SIZE-1:0] value;
  } snoop_t;

  logic [ENTRY_COUNT-1:0] occupied;
  logic [ENTRY_COUNT-1:0] a_loaded;
  logic [ENTRY_COUNT-1:0] b_loaded;
  logic [ENTRY_COUNT-1:0] ready_mask;
  logic [OP_WIDTH-1:0]    entry_operation [ENTRY_COUNT];
  logic [TAG_SIZE-1:0]    a_source        [ENTRY_COUNT];
  logic [TAG_SIZE-1:0]    b_source        [ENTRY_COUNT];
  logic [SIZE-1:0]        a_value         [ENTRY_COUNT];
  logic [SIZE-1:0]        b_value         [ENTRY_COUNT];

  snoop_t a_snoop [ENTRY_COUNT];
  snoop_t b_snoop [ENTRY_COUNT];
  snoop_t load_a_snoop;
  snoop_t load_b_snoop;

  index_t          load_index;
  index_t          issue_index;
  logic            issue_any;
  logic            issue;
  logic            load_fire;
  logic [SIZE-1:0] alu_result;

  // Lowest-index bus carrying the wanted tag wins (buses scanned high to low).
  function automatic snoop_t snoop(
    input logic [TAG_SIZE-1:0]           tag,
    input logic [BUS_COUNT-1:0]          asserted,
    input logic [BUS_COUNT*TAG_SIZE-1:0] sources,
    input logic [BUS_COUNT*SIZE-1:0]     values
  );
    snoop_t found;
    found = '0;
    for (int unsigned k = BUS_COUNT; k > 0; k--) begin
      if (asserted[k-1] && (sources[(k-1)*TAG_SIZE +: TAG_SIZE] == tag)) begin
        found.hit   = 1'b1;
        found.value = values[(k-1)*SIZE +: SIZE];
      end
    end
    return found;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
      a_snoop[i] = snoop(a_source[i], bus_asserted, bus_source, bus_value);
      b_snoop[i] = snoop(b_source[i], bus_asserted, bus_source, bus_value);
    end
    load_a_snoop = snoop(load_a_source, bus_asserted, bus_source, bus_value);
    load_b_snoop = snoop(load_b_source, bus_asserted, bus_source, bus_value);
  end

  assign ready_mask = occupied & a_loaded & b_loaded;

  // Downward scan so the lowest free / lowest ready entry is the one kept.
  always_comb begin
    load_index  = '0;
    load_ready  = 1'b0;
    issue_index = '0;
    issue_any   = 1'b0;
    for (int unsigned i = ENTRY_COUNT; i > 0; i--) begin
      if (!occupied[i-1]) begin
        load_index = index_t'(i - 1);
        load_ready = 1'b1;
      end
      if (ready_mask[i-1]) begin
        issue_index = index_t'(i - 1);
        issue_any   = 1'b1;
      end
    end
  end

  assign load_tag  = TAG_SIZE'(BASE_TAG) + TAG_SIZE'(load_index);
  assign load_fire = load_valid && load_ready;
  assign issue     = issue_any && (!result_valid || result_ready);

  integer_alu #(
    .SIZE(SIZE)
  ) alu (
    .operation (entry_operation[issue_index]),
    .a         (a_value[issue_index]),
    .b         (b_value[issue_index]),
    .result    (alu_result)
  );

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      occupied       <= '0;
      result_valid   <= 1'b0;
      result_tag     <= '0;
      result_value   <= '0;
      occupied_count <= '0;
    end else begin
      if (issue) begin
        occupied[issue_index] <= 1'b0;
        result_valid          <= 1'b1;
        result_tag            <= TAG_SIZE'(BASE_TAG) + TAG_SIZE'(issue_index);
        result_value          <= alu_result;
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
      // load_index is always a free entry, issue_index an occupied one,
      // so the two writes never collide.
      if (load_fire) begin
        occupied[load_index] <= 1'b1;
      end
      occupied_count <= occupied_count + COUNT_SIZE'(load_fire) - COUNT_SIZE'(issue);
    end
  end

  // Payload needs no reset: it is only observed through an occupied entry,
  // and a load always rewrites every field of its entry.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
      if (!a_loaded[i] && a_snoop[i].hit) begin
        a_loaded[i] <= 1'b1;
        a_value[i]  <= a_snoop[i].value;
      end
      if (!b_loaded[i] && b_snoop[i].hit) begin
        b_loaded[i] <= 1'b1;
        b_value[i]  <= b_snoop[i].value;
      end
    end
    if (load_fire) begin
      entry_operation[load_index] <= load_operation;
      a_source[load_index]        <= load_a_source;
      a_loaded[load_index]        <= load_a_preloaded || load_a_snoop.hit;
      a_value[load_index]         <= load_a_preloaded ? load_a_value : load_a_snoop.value;
      b_source[load_index]        <= load_b_source;
      b_loaded[load_index]        <= load_b_preloaded || load_b_snoop.hit;
      b_value[load_index]         <= load_b_preloaded ? load_b_value : load_b_snoop.value;
    end
  end

endmodule

// File: tb/tb_integer_reservation_station.sv
// Self-checking bench for integer_reservation_station: expected results are
// queued when ops are dispatched and compared when the result port handshakes.
module tb_integer_reservation_station;

  localparam int SIZE        = 32;
  localparam int ENTRY_COUNT = 4;
  localparam int TAG_SIZE    = 4;
  localparam int BASE_TAG    = 8;
  localparam int BUS_COUNT   = 2;
  localparam int COUNT_SIZE  = $clog2(ENTRY_COUNT + 1);

  typedef struct {
    logic [TAG_SIZE-1:0] tag;
    logic [SIZE-1:0]     value;
  } result_entry_t;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          flush;
  logic                          load_valid;
  logic                          load_ready;
  logic [TAG_SIZE-1:0]           load_tag;
  logic [3:0]                    load_operation;
  logic                          load_a_preloaded;
  logic [TAG_SIZE-1:0]           load_a_source;
  logic [SIZE-1:0]               load_a_value;
  logic                          load_b_preloaded;
  logic [TAG_SIZE-1:0]           load_b_source;
  logic [SIZE-1:0]               load_b_value;
  logic [BUS_COUNT-1:0]          bus_asserted;
  logic [BUS_COUNT*TAG_SIZE-1:0] bus_source;
  logic [BUS_COUNT*SIZE-1:0]     bus_value;
  logic                          result_valid;
  logic                          result_ready;
  logic [TAG_SIZE-1:0]           result_tag;
  logic [SIZE-1:0]               result_value;
  logic [COUNT_SIZE-1:0]         occupied_count;

  result_entry_t sb[$];
  result_entry_t popped;
  int            assertion_count = 0;
  int            failure_count   = 0;

  logic [3:0]  t5_op [15] = '{4'd7, 4'd9, 4'd8, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
                              4'd4, 4'd5, 4'd6, 4'd9, 4'd8, 4'd10, 4'd7};
  logic [31:0] t5_a  [15] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                              32'hFFFF_FFFF, 32'd0, 32'hF0, 32'hF0, 32'hFF, 32'd1,
                              32'h8000_0000, 32'd1, 32'd1, 32'd7, 32'h4000_0000};
  logic [31:0] t5_b  [15] = '{32'd31, 32'd1, 32'd1, 32'd3, 32'd1, 32'd1, 32'h0F,
                              32'h3C, 32'h0F, 32'd33, 32'd31, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd7, 32'd2};
  logic [31:0] t5_exp[15] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFF, 32'h30, 32'hF0, 32'd2, 32'd1,
                              32'd0, 32'd1, 32'd0, 32'h1000_0000};

  integer_reservation_station #(
    .SIZE       (SIZE),
    .ENTRY_COUNT(ENTRY_COUNT),
    .TAG_SIZE   (TAG_SIZE),
    .BASE_TAG   (BASE_TAG),
    .BUS_COUNT  (BUS_COUNT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_tag        (load_tag),
    .load_operation  (load_operation),
    .load_a_preloaded(load_a_preloaded),
    .load_a_source   (load_a_source),
    .load_a_value    (load_a_value),
    .load_b_preloaded(load_b_preloaded),
    .load_b_source   (load_b_source),
    .load_b_value    (load_b_value),
    .bus_asserted    (bus_asserted),
    .bus_source      (bus_source),
    .bus_value       (bus_value),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_tag      (result_tag),
    .result_value    (result_value),
    .occupied_count  (occupied_count)
  );

  always #5 clock = ~clock;

  task automatic check_equal(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertion_count++;
    if (observed !== expected) begin
      failure_count++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", name, observed, expected);
    end
  endtask

  task automatic push_expected(input int tag, input logic [SIZE-1:0] value);
    result_entry_t e;
    e.tag   = TAG_SIZE'(tag);
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic load_op(input logic [3:0] op,
                         input logic a_pre, input logic [TAG_SIZE-1:0] a_src,
                         input logic [SIZE-1:0] a_val,
                         input logic b_pre, input logic [TAG_SIZE-1:0] b_src,
                         input logic [SIZE-1:0] b_val);
    load_valid       = 1'b1;
    load_operation   = op;
    load_a_preloaded = a_pre;
    load_a_source    = a_src;
    load_a_value     = a_val;
    load_b_preloaded = b_pre;
    load_b_source    = b_src;
    load_b_value     = b_val;
    @(posedge clock); #1;
    load_valid = 1'b0;
  endtask

  task automatic set_bus(input int unsigned idx, input logic [TAG_SIZE-1:0] tag,
                         input logic [SIZE-1:0] value);
    bus_asserted[idx]                    = 1'b1;
    bus_source[idx*TAG_SIZE +: TAG_SIZE] = tag;
    bus_value[idx*SIZE +: SIZE]          = value;
  endtask

  task automatic clear_buses();
    bus_asserted = '0;
    bus_source   = '0;
    bus_value    = '0;
  endtask

  task automatic drain();
    int unsigned cycles = 0;
    while (sb.size() != 0 && cycles < 50) begin
      @(posedge clock);
      cycles++;
    end
    check_equal("drain", sb.size(), 0);
    @(posedge clock); #1;
  endtask

  // Scoreboard side: every accepted result must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && result_valid && result_ready) begin
      check_equal("sb_pending", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        popped = sb.pop_front();
        check_equal("result_tag", result_tag, popped.tag);
        check_equal("result_value", result_value, popped.value);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time limit reached, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    load_valid   = 1'b0;
    result_ready = 1'b0;
    load_op_idle();
    clear_buses();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check_equal("reset_valid", result_valid, 0);
    check_equal("reset_tag", result_tag, 0);
    check_equal("reset_value", result_value, 0);
    check_equal("reset_count", occupied_count, 0);
    check_equal("reset_load_ready", load_ready, 1);
    check_equal("reset_load_tag", load_tag, BASE_TAG);

    // Both operands preloaded.
    @(posedge clock); #1;
    result_ready = 1'b1;
    push_expected(BASE_TAG, 12);
    load_op(4'd0, 1'b1, '0, 32'd5, 1'b1, '0, 32'd7);
    @(negedge clock);
    check_equal("t1_count_after_load", occupied_count, 1);
    check_equal("t1_not_yet_valid", result_valid, 0);
    @(negedge clock);
    check_equal("t1_valid", result_valid, 1);
    check_equal("t1_count_after_issue", occupied_count, 0);
    drain();

    // Wakeup two cycles after load; a non-matching tag must not wake it.
    push_expected(BASE_TAG, 8);
    load_op(4'd1, 1'b0, 4'd3, '0, 1'b1, '0, 32'd2);
    set_bus(0, 4'd4, 32'd99);
    @(negedge clock);
    check_equal("t2_wrong_tag", result_valid, 0);
    @(posedge clock); #1;
    clear_buses();
    set_bus(1, 4'd3, 32'd10);
    @(posedge clock); #1;
    clear_buses();
    @(negedge clock);
    check_equal("t2_not_on_capture_edge", result_valid, 0);
    @(negedge clock);
    check_equal("t2_one_after_capture", result_valid, 1);
    drain();

    // Bus asserted in the load cycle itself.
    push_expected(BASE_TAG, 18);
    set_bus(1, 4'd3, 32'd20);
    load_op(4'd1, 1'b0, 4'd3, '0, 1'b1, '0, 32'd2);
    clear_buses();
    @(negedge clock);
    check_equal("t2b_count", occupied_count, 1);
    drain();

    // Distinct buses for A and B.
    push_expected(BASE_TAG, 6);
    load_op(4'd6, 1'b0, 4'd1, '0, 1'b0, 4'd2, '0);
    set_bus(0, 4'd1, 32'd100);
    set_bus(1, 4'd2, 32'd4);
    @(posedge clock); #1;
    clear_buses();
    drain();

    // One bus satisfying both operands.
    push_expected(BASE_TAG, 42);
    load_op(4'd0, 1'b0, 4'd5, '0, 1'b0, 4'd5, '0);
    set_bus(0, 4'd5, 32'd21);
    @(posedge clock); #1;
    clear_buses();
    drain();

    // Two buses with the same tag: lowest-index bus wins.
    push_expected(BASE_TAG, 50);
    load_op(4'd0, 1'b0, 4'd6, '0, 1'b1, '0, 32'd0);
    set_bus(0, 4'd6, 32'd50);
    set_bus(1, 4'd6, 32'd70);
    @(posedge clock); #1;
    clear_buses();
    drain();

    // Fill and back-pressure.
    result_ready = 1'b0;
    push_expected(BASE_TAG, 1001);
    load_op(4'd0, 1'b1, '0, 32'd1000, 1'b1, '0, 32'd1);
    @(posedge clock); #1;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      push_expected(BASE_TAG + i, SIZE'((i + 1) * 100 + i));
      load_op(4'd0, 1'b1, '0, SIZE'((i + 1) * 100), 1'b1, '0, SIZE'(i));
    end
    @(negedge clock);
    check_equal("t4_full_load_ready", load_ready, 0);
    check_equal("t4_full_count", occupied_count, ENTRY_COUNT);
    check_equal("t4_hold_valid", result_valid, 1);
    check_equal("t4_hold_tag", result_tag, BASE_TAG);
    check_equal("t4_hold_value", result_value, 1001);
    @(posedge clock); #1;
    load_op(4'd0, 1'b1, '0, 32'd9, 1'b1, '0, 32'd9);
    @(negedge clock);
    check_equal("t4_ignored_load_count", occupied_count, ENTRY_COUNT);
    check_equal("t4_still_tag", result_tag, BASE_TAG);
    check_equal("t4_still_value", result_value, 1001);
    @(posedge clock); #1;
    result_ready = 1'b1;
    for (int i = 0; i <= ENTRY_COUNT; i++) begin
      @(negedge clock);
      check_equal("t4_stream_valid", result_valid, 1);
    end
    @(negedge clock);
    check_equal("t4_valid_falls", result_valid, 0);
    check_equal("t4_empty_count", occupied_count, 0);
    drain();

    // ALU ops and boundaries, back-to-back: entries alternate 0,1,0,...
    for (int i = 0; i < 15; i++) begin
      push_expected(BASE_TAG + (i % 2), t5_exp[i]);
      load_op(t5_op[i], 1'b1, '0, t5_a[i], 1'b1, '0, t5_b[i]);
    end
    drain();

    // Flush with occupied entries, a held result and a simultaneous load.
    result_ready = 1'b0;
    load_op(4'd0, 1'b1, '0, 32'd1, 1'b1, '0, 32'd1);
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++)
      load_op(4'd0, 1'b1, '0, SIZE'(i), 1'b1, '0, 32'd1);
    @(negedge clock);
    check_equal("t6_pre_count", occupied_count, 3);
    check_equal("t6_pre_valid", result_valid, 1);
    @(posedge clock); #1;
    flush = 1'b1;
    load_op(4'd0, 1'b1, '0, 32'd77, 1'b1, '0, 32'd1);
    flush = 1'b0;
    @(negedge clock);
    check_equal("t6_count", occupied_count, 0);
    check_equal("t6_valid", result_valid, 0);
    check_equal("t6_tag", result_tag, 0);
    check_equal("t6_value", result_value, 0);
    check_equal("t6_load_ready", load_ready, 1);
    check_equal("t6_load_tag", load_tag, BASE_TAG);
    @(posedge clock); #1;
    result_ready = 1'b1;
    repeat (2) @(negedge clock);
    check_equal("t6_load_discarded", result_valid, 0);
    @(posedge clock); #1;
    push_expected(BASE_TAG, 5);
    load_op(4'd0, 1'b1, '0, 32'd2, 1'b1, '0, 32'd3);
    drain();

    check_equal("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertion_count, failure_count);
    $finish;
  end

  task automatic load_op_idle();
    load_operation   = '0;
    load_a_preloaded = 1'b0;
    load_a_source    = '0;
    load_a_value     = '0;
    load_b_preloaded = 1'b0;
    load_b_source    = '0;
    load_b_value     = '0;
  endtask

endmodule
